// File: rtl/mem_ctrl.sv
// mem_ctrl: single-byte controller for two parallel QPI PSRAMs (A = low nibble, B = high nibble).
// Define MEMCTRL_RESET_CMD_EN to issue ResetEnable/Reset (0x66/0x99) before entering QPI mode.
module mem_ctrl #(
  parameter int INIT_DELAY_CYCLES = 7500,
  parameter int READ_WAIT_CYCLES  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CE,
  input  logic        write,
  input  logic [5:0]  bank,
  input  logic [15:0] addrBus,
  input  logic [7:0]  dataToWrite,
  output logic [7:0]  dataRead,
  output logic        busy,
  inout  wire         io_psram_data0,
  inout  wire         io_psram_data1,
  inout  wire         io_psram_data2,
  inout  wire         io_psram_data3,
  inout  wire         io_psram_data4,
  inout  wire         io_psram_data5,
  inout  wire         io_psram_data6,
  inout  wire         io_psram_data7,
  output logic        o_psram_cs,
  output logic        o_psram_sclk
);
  localparam int DW = $clog2(INIT_DELAY_CYCLES + 2);
  localparam logic [4:0] S_INIT1 = 5'd0, S_INIT2 = 5'd1, S_QPI = 5'd2, S_IDLE = 5'd3,
                         S_WCMDH = 5'd4, S_WCMDL = 5'd5, S_WADDR = 5'd6, S_WDATA = 5'd7,
                         S_RCMDH = 5'd8, S_RCMDL = 5'd9, S_RADDR = 5'd10, S_RWAIT = 5'd11,
                         S_RDATA = 5'd12;
`ifdef MEMCTRL_RESET_CMD_EN
  localparam logic [4:0] S_RSTEN = 5'd13, S_GAP1 = 5'd14, S_RST = 5'd15, S_GAP2 = 5'd16;
`endif
  logic [4:0]    state_q, state_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ce_q, start, serial, sbit;
  logic [23:0]   addr_q;
  logic [7:0]    wdata_q, data_read_q, cmd, oe, dout, io_in;
  logic [2:0]    idx;
  logic [3:0]    anib;
  assign start = state_q == S_IDLE && CE && !ce_q;
`ifdef MEMCTRL_RESET_CMD_EN
  assign serial = state_q == S_QPI || state_q == S_RSTEN || state_q == S_RST;
  assign cmd = state_q == S_RSTEN ? 8'h66 : state_q == S_RST ? 8'h99 : 8'h35;
`else
  assign serial = state_q == S_QPI;
  assign cmd = 8'h35;
`endif
  assign sbit = cmd[3'd7 - cnt_q[2:0]];
  assign idx = 3'd5 - cnt_q[2:0];
  assign anib = addr_q[{idx, 2'b00} +: 4];
  assign o_psram_cs = !(serial || (state_q >= S_WCMDH && state_q <= S_RDATA));
  assign o_psram_sclk = !o_psram_cs && !clk;
  assign busy = state_q != S_IDLE;
  assign dataRead = data_read_q;
  // Serial commands use only SIO0 of each chip; QPI phases mirror nibbles onto both chips.
  always_comb begin
    oe = serial ? 8'h11 : (o_psram_cs || state_q == S_RWAIT || state_q == S_RDATA) ? 8'h00 : 8'hFF;
    dout = serial ? {2{3'b000, sbit}} : state_q == S_WCMDH ? 8'h33 : state_q == S_WCMDL ? 8'h88 :
           state_q == S_RCMDH ? 8'hEE : state_q == S_RCMDL ? 8'hBB :
           state_q == S_WDATA ? wdata_q : {2{anib}};
  end
  assign io_psram_data0 = oe[0] ? dout[0] : 1'bz;
  assign io_psram_data1 = oe[1] ? dout[1] : 1'bz;
  assign io_psram_data2 = oe[2] ? dout[2] : 1'bz;
  assign io_psram_data3 = oe[3] ? dout[3] : 1'bz;
  assign io_psram_data4 = oe[4] ? dout[4] : 1'bz;
  assign io_psram_data5 = oe[5] ? dout[5] : 1'bz;
  assign io_psram_data6 = oe[6] ? dout[6] : 1'bz;
  assign io_psram_data7 = oe[7] ? dout[7] : 1'bz;
  assign io_in = {io_psram_data7, io_psram_data6, io_psram_data5, io_psram_data4,
                  io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    delay_d = delay_q;
    case (state_q)
      S_INIT1: begin
        delay_d = delay_q - 1'b1;
        state_d = delay_q <= DW'(1) ? S_INIT2 : S_INIT1;
      end
`ifdef MEMCTRL_RESET_CMD_EN
      S_INIT2: state_d = S_RSTEN;
      S_RSTEN: begin
        cnt_d = cnt_q == 4'd7 ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == 4'd7 ? S_GAP1 : S_RSTEN;
      end
      S_GAP1: state_d = S_RST;
      S_RST: begin
        cnt_d = cnt_q == 4'd7 ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == 4'd7 ? S_GAP2 : S_RST;
      end
      S_GAP2: state_d = S_QPI;
`else
      S_INIT2: state_d = S_QPI;
`endif
      S_QPI: begin
        cnt_d = cnt_q == 4'd7 ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == 4'd7 ? S_IDLE : S_QPI;
      end
      S_IDLE: state_d = !start ? S_IDLE : write ? S_WCMDH : S_RCMDH;
      S_WCMDH: state_d = S_WCMDL;
      S_WCMDL: state_d = S_WADDR;
      S_WADDR: begin
        cnt_d = cnt_q == 4'd5 ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == 4'd5 ? S_WDATA : S_WADDR;
      end
      S_WDATA: state_d = S_IDLE;
      S_RCMDH: state_d = S_RCMDL;
      S_RCMDL: state_d = S_RADDR;
      S_RADDR: begin
        cnt_d = cnt_q == 4'd5 ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == 4'd5 ? S_RWAIT : S_RADDR;
      end
      S_RWAIT: begin
        cnt_d = cnt_q == 4'(READ_WAIT_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == 4'(READ_WAIT_CYCLES - 1) ? S_RDATA : S_RWAIT;
      end
      S_RDATA: state_d = S_IDLE;
      default: state_d = S_INIT1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT1;
      delay_q <= DW'(INIT_DELAY_CYCLES);
      cnt_q <= '0;
      ce_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      data_read_q <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      cnt_q <= cnt_d;
      ce_q <= CE;
      if (start) begin
        addr_q <= {2'b00, bank, addrBus};
        wdata_q <= dataToWrite;
      end
      if (state_q == S_RDATA) data_read_q <= io_in;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a pulled-up PSRAM bus model.
module tb_mem_ctrl;
  localparam int N = 7500, RW = 6;
  logic clk = 1'b0, reset = 1'b1, CE = 1'b0, write = 1'b0;
  logic [5:0] bank = '0;
  logic [15:0] addr_bus = '0;
  logic [7:0] data_to_write = '0, data_read, drv = '0;
  logic busy, cs, sclk, drv_en = 1'b0;
  wire [7:0] io;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 8; g++) begin : g_io
    pullup (io[g]);
    assign io[g] = drv_en ? drv[g] : 1'bz;
  end
  mem_ctrl #(.INIT_DELAY_CYCLES(N), .READ_WAIT_CYCLES(RW)) dut (
    .clk(clk), .reset(reset), .CE(CE), .write(write), .bank(bank), .addrBus(addr_bus),
    .dataToWrite(data_to_write), .dataRead(data_read), .busy(busy),
    .io_psram_data0(io[0]), .io_psram_data1(io[1]), .io_psram_data2(io[2]), .io_psram_data3(io[3]),
    .io_psram_data4(io[4]), .io_psram_data5(io[5]), .io_psram_data6(io[6]), .io_psram_data7(io[7]),
    .o_psram_cs(cs), .o_psram_sclk(sclk)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pins();
    return {21'b0, cs, busy, sclk, io};
  endfunction
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic ser(input string tag, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      check(tag, pins(), {3'b011, 3'b111, b[7-i], 3'b111, b[7-i]});
    end
  endtask
  task automatic init_seq();
    int k = 0;
    do begin
      step();
      k++;
    end while (cs && k < N + 40);
    check("init_len", k, N + 1);
`ifdef MEMCTRL_RESET_CMD_EN
    ser("rst_en_cmd", 8'h66);
    step();
    check("gap1", pins(), {3'b110, 8'hFF});
    step();
    ser("rst_cmd", 8'h99);
    step();
    check("gap2", pins(), {3'b110, 8'hFF});
    step();
`endif
    ser("qpi_cmd", 8'h35);
    step();
    check("qpi_done", pins(), {3'b100, 8'hFF});
  endtask
  task automatic txn(input logic wr, input logic [5:0] bk, input logic [15:0] ad,
                     input logic [7:0] dat, input logic poke);
    logic [23:0] a;
    logic [7:0] e[$];
    a = {2'b00, bk, ad};
    e.push_back(wr ? 8'h33 : 8'hEE);
    e.push_back(wr ? 8'h88 : 8'hBB);
    for (int i = 5; i >= 0; i--) e.push_back({2{a[4*i +: 4]}});
    if (wr) e.push_back(dat);
    else repeat (RW) e.push_back(8'hFF);
    CE = 1'b0;
    step();
    CE = 1'b1;
    write = wr;
    bank = bk;
    addr_bus = ad;
    data_to_write = wr ? dat : 8'h00;
    foreach (e[i]) begin
      step();
      bank = ~bk;
      addr_bus = ~ad;
      data_to_write = ~dat;
      write = ~wr;
      if (poke) CE = i[0];
      check(wr ? "wr_cycle" : "rd_cycle", pins(), {3'b011, e[i]});
    end
    if (!wr) begin
      step();
      drv = dat;
      drv_en = 1'b1;
      check("rd_data_cycle", pins() >> 8, 32'd3);
    end
    step();
    drv_en = 1'b0;
    #1;
    check("txn_end", pins(), {3'b100, 8'hFF});
    if (!wr) check("dataRead", data_read, dat);
    if (poke) repeat (3) begin
      step();
      check("no_queue", pins(), {3'b100, 8'hFF});
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int bad = 0;
    repeat (3) @(posedge clk);
    step();
    check("rst_pins", pins(), {3'b110, 8'hFF});
    check("rst_dataRead", data_read, 0);
    reset = 1'b0;
    init_seq();
    txn(1'b1, 6'h00, 16'hC000, 8'hAA, 1'b0);
    repeat (1000) begin
      step();
      if (cs !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("ce_hold", bad, 0);
    txn(1'b0, 6'h00, 16'hC000, 8'h5A, 1'b0);
    txn(1'b1, 6'h2A, 16'h1234, 8'h5C, 1'b1);
    check("dataRead_hold", data_read, 8'h5A);
    txn(1'b0, 6'h2A, 16'h1234, 8'hC3, 1'b0);
    CE = 1'b0;
    step();
    CE = 1'b1;
    write = 1'b1;
    bank = 6'h3F;
    addr_bus = 16'h5AC3;
    data_to_write = 8'h77;
    repeat (5) step();
    check("pre_abort", pins(), {3'b011, 8'h55});
    reset = 1'b1;
    CE = 1'b0;
    step();
    check("abort_pins", pins(), {3'b110, 8'hFF});
    check("abort_dataRead", data_read, 0);
    reset = 1'b0;
    init_seq();
    txn(1'b0, 6'h15, 16'hFFFF, 8'h96, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
